// File: rtl/common.sv
// Scalar types shared across the core datapath: architectural register
// index and 64-bit data word.
package common;
  typedef logic [4:0]  creg_addr_t;
  typedef logic [63:0] u64;
endpackage

// File: rtl/config_pkg.sv
// Build-time configuration knobs for the core.
package config_pkg;
  localparam int NUM_WB_REQ = 3;
endpackage

// File: rtl/wb_arbiter_pkg.sv
// Types and helpers local to the writeback arbiter: the registered
// regfile write bundle and the round-robin pointer advance.
package wb_arbiter_pkg;
  import common::*;

  localparam int NumRegs = 32;

  typedef struct packed {
    logic       valid;
    creg_addr_t addr;
    u64         data;
  } wb_out_t;

  localparam wb_out_t WbOutIdle = '{valid: 1'b0, addr: '0, data: '0};

  function automatic int wrapInc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: picks the first valid requester at or after the
// priority pointer, returning a one-hot grant and its index.
module rr_arbiter #(
  parameter int N    = 3,
  parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    valid_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [IdxW-1:0] idx_o
);

  // Scan offsets 0..N-1 from the pointer; the first valid hit wins.
  always_comb begin
    logic found;
    found   = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && valid_i[i] && (i == (int'(ptr_i) + k) % N)) begin
          found      = 1'b1;
          grant_o[i] = 1'b1;
          idx_o      = IdxW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin funnel of several writeback sources onto
// the single regfile write port, plus the pending-write busy scoreboard.
module wb_arbiter
  import common::*;
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = config_pkg::NUM_WB_REQ
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  creg_addr_t         req_addr [NUM_REQ],
  input  u64                 req_data [NUM_REQ],
  input  logic               mark_valid,
  input  creg_addr_t         mark_addr,
  input  logic               flush,
  output creg_addr_t         wa,
  output logic               wvalid,
  output u64                 wd,
  output logic [31:0]        busy
);

  localparam int IdxW = $clog2(NUM_REQ);

  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [IdxW-1:0]    grantIdx;
  logic [NUM_REQ-1:0] grant;
  logic               accept;
  creg_addr_t         selAddr;
  u64                 selData;
  wb_out_t            out_q, out_d;
  logic [NumRegs-1:0] busy_q, busy_d;

  rr_arbiter #(
    .N    (NUM_REQ),
    .IdxW (IdxW)
  ) u_rr (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grantIdx)
  );

  // reset is active-low: no requester is granted while it is held at 0.
  assign req_ready = reset ? grant : '0;
  assign accept    = |req_ready;

  always_comb begin
    selAddr = '0;
    selData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        selAddr = req_addr[i];
        selData = req_data[i];
      end
    end
  end

  // Writes to r0 are consumed but never reach the regfile, and wa/wd keep
  // their previous contents whenever nothing is written.
  always_comb begin
    out_d       = out_q;
    out_d.valid = 1'b0;
    if (accept && (selAddr != '0)) begin
      out_d.valid = 1'b1;
      out_d.addr  = selAddr;
      out_d.data  = selData;
    end
    ptr_d = accept ? IdxW'(wrapInc(int'(grantIdx), NUM_REQ)) : ptr_q;
  end

  always_comb begin
    busy_d = busy_q;
    if (out_q.valid) busy_d[out_q.addr] = 1'b0;
    if (mark_valid)  busy_d[mark_addr]  = 1'b1;
    busy_d[0] = 1'b0;
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q  <= '0;
      out_q  <= WbOutIdle;
      busy_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      out_q  <= out_d;
      busy_q <= busy_d;
    end
  end

  assign wvalid = out_q.valid;
  assign wa     = out_q.addr;
  assign wd     = out_q.data;
  assign busy   = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected regfile writes are queued as
// requests are issued and popped by a monitor whenever wvalid is seen.
module tb_wb_arbiter;
  import common::*;

  typedef struct packed {
    creg_addr_t addr;
    u64         data;
  } wr_t;

  logic        clk;
  logic        reset;
  logic [2:0]  reqValid;
  logic [2:0]  reqReady;
  creg_addr_t  reqAddr [3];
  u64          reqData [3];
  logic        markValid;
  creg_addr_t  markAddr;
  logic        flush;
  creg_addr_t  wa;
  logic        wvalid;
  u64          wd;
  logic [31:0] busy;

  wr_t expQ[$];
  wr_t expWr;
  int  compared   = 0;
  int  mismatched = 0;

  wb_arbiter #(.NUM_REQ(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (reqValid),
    .req_ready  (reqReady),
    .req_addr   (reqAddr),
    .req_data   (reqData),
    .mark_valid (markValid),
    .mark_addr  (markAddr),
    .flush      (flush),
    .wa         (wa),
    .wvalid     (wvalid),
    .wd         (wd),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input creg_addr_t addr, input u64 data);
    reqAddr[idx] = addr;
    reqData[idx] = data;
  endtask

  task automatic expectWrite(input creg_addr_t addr, input u64 data);
    expQ.push_back('{addr: addr, data: data});
  endtask

  // Monitor: every regfile write must match the oldest expected write.
  always @(negedge clk) begin
    if (wvalid === 1'b1) begin
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL write-unexpected: got wa=%0d wd=0x%0h, expected no write", wa, wd);
      end else begin
        expWr = expQ.pop_front();
        if (wa !== expWr.addr || wd !== expWr.data) begin
          mismatched++;
          $display("[TB] FAIL write-data: got wa=%0d wd=0x%0h, expected wa=%0d wd=0x%0h",
                   wa, wd, expWr.addr, expWr.data);
        end
      end
    end
  end

  initial begin
    logic [2:0] satReady [6];
    satReady[0] = 3'b010; satReady[1] = 3'b100; satReady[2] = 3'b001;
    satReady[3] = 3'b010; satReady[4] = 3'b100; satReady[5] = 3'b001;

    reset     = 1'b1;
    reqValid  = 3'b111;
    markValid = 1'b0;
    markAddr  = '0;
    flush     = 1'b0;
    applyStimulus(0, 5'd1, 64'hA);
    applyStimulus(1, 5'd2, 64'hB);
    applyStimulus(2, 5'd3, 64'hC);
    #1 reset = 1'b0;

    // Reset state with all three requesters pending
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset-wvalid", 64'(wvalid), 64'h0);
    checkOutput("reset-wa", 64'(wa), 64'h0);
    checkOutput("reset-wd", wd, 64'h0);
    checkOutput("reset-busy", 64'(busy), 64'h0);
    checkOutput("reset-ready", 64'(reqReady), 64'h0);

    // Release: grants 0,1,2 in consecutive cycles
    reset = 1'b1;
    expectWrite(5'd1, 64'hA);
    expectWrite(5'd2, 64'hB);
    expectWrite(5'd3, 64'hC);
    #2 checkOutput("rr-grant0", 64'(reqReady), 64'b001);
    nextCycle(); reqValid = 3'b110;
    #2 checkOutput("rr-grant1", 64'(reqReady), 64'b010);
    nextCycle(); reqValid = 3'b100;
    #2 checkOutput("rr-grant2", 64'(reqReady), 64'b100);
    nextCycle(); reqValid = 3'b000;
    #2 checkOutput("rr-idle-ready", 64'(reqReady), 64'h0);
    nextCycle();
    #2 checkOutput("idle-wvalid", 64'(wvalid), 64'h0);
    checkOutput("idle-hold-wa", 64'(wa), 64'd3);
    checkOutput("idle-hold-wd", wd, 64'hC);

    // Mark r5, then write r5: busy until the write retires
    nextCycle(); markValid = 1'b1; markAddr = 5'd5;
    #2 checkOutput("mark5-before", 64'(busy[5]), 64'h0);
    nextCycle(); markValid = 1'b0;
    applyStimulus(1, 5'd5, 64'h55); reqValid = 3'b010;
    expectWrite(5'd5, 64'h55);
    #2 checkOutput("mark5-set", 64'(busy[5]), 64'h1);
    checkOutput("mark5-ready", 64'(reqReady), 64'b010);
    nextCycle(); reqValid = 3'b000;
    #2 checkOutput("mark5-during-write", 64'(busy[5]), 64'h1);
    nextCycle();
    #2 checkOutput("mark5-cleared", 64'(busy[5]), 64'h0);

    // Mark r7 in the same cycle that r7 is written: mark wins
    nextCycle(); markValid = 1'b1; markAddr = 5'd7;
    applyStimulus(2, 5'd7, 64'h77); reqValid = 3'b100;
    expectWrite(5'd7, 64'h77);
    #2 checkOutput("mark7-ready", 64'(reqReady), 64'b100);
    nextCycle(); reqValid = 3'b000;
    #2 checkOutput("mark7-set", 64'(busy[7]), 64'h1);
    nextCycle(); markAddr = 5'd4;
    #2 checkOutput("mark7-wins", 64'(busy[7]), 64'h1);
    nextCycle(); markAddr = 5'd5;
    nextCycle(); markAddr = 5'd6;
    nextCycle(); markValid = 1'b0;
    #2 checkOutput("busy-f0", 64'(busy), 64'h0000_00F0);

    // Flush beats a simultaneous mark of r9
    nextCycle(); flush = 1'b1; markValid = 1'b1; markAddr = 5'd9;
    nextCycle(); flush = 1'b0; markValid = 1'b0;
    #2 checkOutput("flush-busy", 64'(busy), 64'h0);
    checkOutput("flush-hold-wa", 64'(wa), 64'd7);
    checkOutput("flush-hold-wd", wd, 64'h77);

    // Write to r0 is consumed but never reaches the regfile
    nextCycle(); applyStimulus(0, 5'd0, 64'hFFFF); reqValid = 3'b001;
    #2 checkOutput("r0-ready", 64'(reqReady), 64'b001);
    nextCycle(); reqValid = 3'b000;
    #2 checkOutput("r0-wvalid", 64'(wvalid), 64'h0);
    checkOutput("r0-busy", 64'(busy), 64'h0);
    checkOutput("r0-hold-wa", 64'(wa), 64'd7);

    // Saturation starting with pointer at 1
    nextCycle();
    applyStimulus(0, 5'd10, 64'h1010);
    applyStimulus(1, 5'd11, 64'h1111);
    applyStimulus(2, 5'd12, 64'h1212);
    reqValid = 3'b111;
    for (int r = 0; r < 2; r++) begin
      expectWrite(5'd11, 64'h1111);
      expectWrite(5'd12, 64'h1212);
      expectWrite(5'd10, 64'h1010);
    end
    for (int k = 0; k < 6; k++) begin
      #2 checkOutput("sat-ready", 64'(reqReady), 64'(satReady[k]));
      nextCycle();
    end
    reqValid = 3'b000;
    nextCycle();

    // Reset mid-write: output cleared asynchronously, pointer back to 0
    nextCycle(); applyStimulus(1, 5'd20, 64'h2020); reqValid = 3'b010;
    markValid = 1'b1; markAddr = 5'd3;
    #2 checkOutput("pre-reset-ready", 64'(reqReady), 64'b010);
    nextCycle(); reqValid = 3'b000; markValid = 1'b0;
    checkOutput("pre-reset-wvalid", 64'(wvalid), 64'h1);
    checkOutput("pre-reset-wa", 64'(wa), 64'd20);
    checkOutput("pre-reset-busy", 64'(busy), 64'h8);
    #1 reset = 1'b0;
    #1 checkOutput("async-reset-wvalid", 64'(wvalid), 64'h0);
    checkOutput("async-reset-wa", 64'(wa), 64'h0);
    checkOutput("async-reset-wd", wd, 64'h0);
    checkOutput("async-reset-busy", 64'(busy), 64'h0);
    applyStimulus(0, 5'd21, 64'h21);
    applyStimulus(2, 5'd22, 64'h22);
    reqValid = 3'b101;
    #1 checkOutput("in-reset-ready", 64'(reqReady), 64'h0);

    nextCycle(); reset = 1'b1;
    expectWrite(5'd21, 64'h21);
    expectWrite(5'd22, 64'h22);
    #2 checkOutput("post-reset-grant0", 64'(reqReady), 64'b001);
    nextCycle(); reqValid = 3'b100;
    #2 checkOutput("post-reset-grant2", 64'(reqReady), 64'b100);
    nextCycle(); reqValid = 3'b000;
    repeat (3) nextCycle();
    checkOutput("scoreboard-drained", 64'(expQ.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
